// File: rtl/qtake_lvl_if.sv
// Valid/ready stream interface used for the cfg, din and dout channels.
//   valid : producer has an item on data
//   ready : consumer accepts the item this cycle
//   data  : payload, W bits
interface qtake_lvl_if #(parameter int W = 8);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input  ready);
  modport consumer (input  valid, input  data, output ready);
endinterface

// File: rtl/qtake_lvl.sv
// qtake_lvl: per outer transaction, passes only the first N sub-transactions.
// Sub-transactions are delimited by eot[CNT_LVL]. The outer transaction is
// delimited by eot[EOT_W-1]. N is taken from cfg.data. The item that ends the
// Nth sub-transaction has its eot bits above CNT_LVL forced high. Everything
// after that item, up to the outer eot, is consumed silently. N=0 drops the
// whole outer transaction.
//   clk, rst : clock, async active-high reset
//   cfg      : consumer, take count N; ready pulses on the outer-eot handshake
//   din      : consumer, {eot[EOT_W-1:0], data[DIN_W-1:0]}
//   dout     : producer, same layout, registered (1-cycle latency)
module qtake_lvl #(
  parameter int DIN_W   = 16,
  parameter int EOT_W   = 2,
  parameter int CNT_LVL = 0,
  parameter int CFG_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  qtake_lvl_if.consumer    cfg,
  qtake_lvl_if.consumer    din,
  qtake_lvl_if.producer    dout
);
  localparam int W = EOT_W + DIN_W;
  // eot bits above the counting level; forced high on the last kept item
  localparam logic [EOT_W-1:0] UP_MASK = {EOT_W{1'b1}} << (CNT_LVL + 1);

  typedef enum logic {TAKE, DROP} state_e;

  state_e           state_q, state_d;
  logic [CFG_W-1:0] cnt_q, cnt_d, cnt_next;
  logic             dv_q, dv_d;
  logic [W-1:0]     dd_q, dd_d;

  logic [EOT_W-1:0] eot_in;
  logic drop_item, free, in_hs, sub_end, outer_end, last_sub, pass;

  always_comb begin
    eot_in    = din.data[W-1:DIN_W];
    drop_item = (state_q == DROP) | (cfg.data == '0);
    free      = !dv_q | dout.ready;
    // dropped items never touch the output register, so they ignore backpressure
    din.ready = cfg.valid & (drop_item | free);
    in_hs     = din.valid & din.ready;
    sub_end   = in_hs & eot_in[CNT_LVL];
    outer_end = in_hs & eot_in[EOT_W-1];
    pass      = in_hs & !drop_item;
    cnt_next  = cnt_q + 1'b1;
    last_sub  = (cnt_next == cfg.data);
    cfg.ready = outer_end;

    dv_d = dv_q;
    dd_d = dd_q;
    if (pass) begin
      dv_d = 1'b1;
      dd_d = din.data;
      if (sub_end & last_sub) dd_d = din.data | {UP_MASK, {DIN_W{1'b0}}};
    end else if (dout.ready) begin
      dv_d = 1'b0;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    // outer end wins over the TAKE->DROP move on the same item
    if (outer_end) begin
      state_d = TAKE;
      cnt_d   = '0;
    end else if (pass & sub_end) begin
      // counting only on passed items keeps cnt <= N, and at 0 when N=0
      if (last_sub) state_d = DROP;
      else          cnt_d   = cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TAKE;
      cnt_q   <= '0;
      dv_q    <= 1'b0;
      dd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dv_q    <= dv_d;
      dd_q    <= dd_d;
    end
  end

  assign dout.valid = dv_q;
  assign dout.data  = dd_q;
endmodule

// File: doc/qtake_lvl.md
Name: qtake_lvl

Overview:
- Parametrised successor to the two-level queue take block.
- Per outer transaction, passes only the first N sub-transactions at a selectable eot level, where N is read from cfg. All remaining items up to the outer eot are dropped.
- Adds an arbitrary eot depth, a selectable counting level and correct handling of N=0. The output is registered, so the block sits between dti stages without a combinational din-to-dout path.

Parameters:
- DIN_W, 16, payload data width (excluding eot bits)
- EOT_W, 2, number of eot levels (>=2); eot[EOT_W-1] is the outer transaction end
- CNT_LVL, 0, eot bit that delimits the counted sub-transactions (0..EOT_W-2)
- CFG_W, 16, width of the take count N

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cfg  dti.consumer  CFG_W  take count N; held valid for a whole outer transaction
- din  dti.consumer  EOT_W+DIN_W  {eot[EOT_W-1:0], data[DIN_W-1:0]}; eot in the MSBs
- dout  dti.producer  EOT_W+DIN_W  same layout as din

Behaviour:
- Reset (async):
  - dout.valid=0, dout data register=0.
  - cnt=0, state=TAKE.
  - cfg.ready and din.ready are combinational, so both are 0 while cfg.valid=0.
- Handshakes:
  - in_hs = din.valid & din.ready; out_hs = dout.valid & dout.ready.
  - The output register is free when (!dout.valid | dout.ready).
- Drop decision: drop_item = (state==DROP) | (cfg.data==0).
- din.ready:
  - drop_item=1: din.ready = cfg.valid.
  - otherwise: din.ready = cfg.valid & free.
  - din is never accepted without cfg.valid.
- Pass path (in_hs & !drop_item):
  - Load the output register next cycle: dout.valid<=1.
  - data copied unchanged; eot[CNT_LVL:0] copied unchanged.
  - eot[EOT_W-1:CNT_LVL+1] forced to all ones when the item ends the Nth sub-transaction (last_sub); otherwise copied.
  - Latency is exactly 1 cycle from in_hs to dout.valid.
- Sub-transaction end: sub_end = in_hs & din.eot[CNT_LVL].
- Output register hold/clear:
  - out_hs with no new load: dout.valid<=0.
  - dout.valid=1 & !dout.ready: register holds.
- Counter (TAKE only):
  - Sub-transaction end: cnt_next = cnt+1; last_sub = (cnt_next == cfg.data).
  - On sub_end & last_sub & !outer_end: state<=DROP, cnt holds.
  - On sub_end & !last_sub: cnt<=cnt_next.
  - cnt never exceeds cfg.data, so no wrap-around is possible.
- DROP: items are consumed with no output.
- Outer end (in_hs & din.eot[EOT_W-1]), either state:
  - cfg.ready=1 in the same cycle (combinational).
  - cnt<=0, state<=TAKE.
  - Outer end takes priority over the DROP transition when both occur on the same item.
- Short transactions: an outer eot arriving before N sub-transactions is passed unchanged and cnt resets. Nothing is padded.
- cfg.data=0: the whole outer transaction is consumed with no output; cfg.ready pulses on its outer eot item.
- cfg.data is sampled combinationally each cycle and must stay stable while cfg.valid=1 (dti rule). It is not latched.
- Reset mid-transaction:
  - The pending dout item is discarded; the counter and state clear.
  - Upstream must restart the transaction.
- Sustained throughput is 1 item/cycle when dout.ready=1.

Test Plan:
- EOT_W=2, CNT_LVL=0, N=2; din = 4 sub-transactions of 3 items ending with eot=2'b11 -> dout = 6 items; item 6 eot=2'b11; items 7-12 dropped; cfg.ready high only on the din item with eot=2'b11.
- N=0; 5-item transaction -> no dout.valid; 5 din handshakes; cfg.ready on the 5th.
- N=5 against 3 sub-transactions -> all items pass unchanged; cfg.ready on the final item; next transaction starts with cnt=0.
- EOT_W=3, CNT_LVL=1, N=1; input with 2 level-1 groups, each of 2 level-0 groups -> first group output; its last item has eot=3'b111; the rest is dropped.
- Random dout.ready backpressure at 50%, N=3 -> data order and eot identical to the zero-backpressure run; dout.data stable while dout.valid & !dout.ready.
- Assert rst mid-transaction while dout.valid=1 -> dout.valid=0 immediately (async); the next transaction with N=1 behaves as from reset.
